encoder_speed_meter: RTL and testbench

ENCODER_SPEED_METER -- requirements
Module: encoder_speed_meter

---
 rtl/encoder_speed_meter.sv | 199 +++++++++++++++++++
 tb/tb_encoder_speed_meter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/encoder_speed_meter.sv
// -----------------------------------------------------------------------------
// encoder_speed_meter
//
// Measures wheel speed and distance from two quadrature-less encoder pulse
// trains (left/right). Each input is synchronized, debounced and edge-detected.
// Rising edges are accumulated over a fixed clock window and published once per
// window, and are also summed into free-running odometer counters.
//
// Ports
//   clk         system clock, all state on its rising edge
//   n_rst       asynchronous active-low reset
//   fbl, fbr    left / right encoder pulse (asynchronous to clk)
//   clr         synchronous clear of timer, accumulators and all outputs
//   out_edge_l  left rising-edge count of the last completed window
//   out_edge_r  right rising-edge count of the last completed window
//   valid       one-cycle strobe coincident with new out_edge_l/out_edge_r
//   odo_l       left cumulative edge count (wrapping)
//   odo_r       right cumulative edge count (wrapping)
// -----------------------------------------------------------------------------
module encoder_speed_meter #(
  parameter int unsigned WINDOW_CNT = 16384,
  parameter int unsigned FILT_LEN   = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        fbl,
  input  logic        fbr,
  input  logic        clr,
  output logic [15:0] out_edge_l,
  output logic [15:0] out_edge_r,
  output logic        valid,
  output logic [31:0] odo_l,
  output logic [31:0] odo_r
);

  // Last timer value of a window and last stability count before acceptance.
  localparam logic [23:0] WIN_LAST  = 24'(WINDOW_CNT - 1);
  localparam logic [3:0]  FILT_LAST = 4'(FILT_LEN - 1);

  // Saturating 16-bit increment used by the per-window accumulators.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    logic [15:0] r;
    if (inc && (v != 16'hFFFF)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Bit 0 is the left side, bit 1 the right side throughout.
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       filt_r;
  logic [1:0]       filt_d_r;
  logic [1:0][3:0]  fcnt_r;
  logic [1:0]       filt_nxt_s;
  logic [1:0][3:0]  fcnt_nxt_s;
  logic [1:0]       edge_s;

  logic             srst_s;
  logic             run_r;
  logic [23:0]      timer_r;
  logic [23:0]      timer_nxt_s;
  logic             close_s;

  logic [15:0]      acc_left_r;
  logic [15:0]      acc_right_r;
  logic [15:0]      acc_left_nxt_s;
  logic [15:0]      acc_right_nxt_s;
  logic [15:0]      out_left_r;
  logic [15:0]      out_right_r;
  logic             valid_r;
  logic [31:0]      odo_left_r;
  logic [31:0]      odo_right_r;

  // clr acts as the block's synchronous soft reset for the measurement path;
  // synchronizer and filter state deliberately ignore it.
  assign srst_s = clr;

  // Stability filter: the level is accepted only after FILT_LEN consecutive
  // cycles of disagreement; any agreeing cycle restarts the count.
  always_comb begin
    filt_nxt_s = filt_r;
    fcnt_nxt_s = 8'h00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_r[i] != filt_r[i]) begin
        if (fcnt_r[i] == FILT_LAST) begin
          filt_nxt_s[i] = sync2_r[i];
          fcnt_nxt_s[i] = 4'd0;
        end else begin
          fcnt_nxt_s[i] = fcnt_r[i] + 4'd1;
        end
      end else begin
        fcnt_nxt_s[i] = 4'd0;
      end
    end
  end

  // Two-flop synchronizer, filtered level and previous filtered level per side.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      filt_r   <= 2'b00;
      filt_d_r <= 2'b00;
      fcnt_r   <= 8'h00;
    end else begin
      sync1_r  <= {fbr, fbl};
      sync2_r  <= sync1_r;
      filt_r   <= filt_nxt_s;
      filt_d_r <= filt_r;
      fcnt_r   <= fcnt_nxt_s;
    end
  end

  // One detected edge per filtered 0->1 transition; filt_d_r is the edge
  // register that gives the final cycle of input-to-counter latency.
  assign edge_s = filt_r & ~filt_d_r;

  // Window timer next state. The timer holds 0 through the first clock after
  // reset so the first window closes WINDOW_CNT+1 cycles after release.
  always_comb begin
    timer_nxt_s = timer_r;
    close_s     = 1'b0;
    if (!run_r) begin
      timer_nxt_s = 24'd0;
    end else if (timer_r == WIN_LAST) begin
      timer_nxt_s = 24'd0;
      close_s     = 1'b1;
    end else begin
      timer_nxt_s = timer_r + 24'd1;
    end
  end

  // Window timer and run flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run_r   <= 1'b0;
      timer_r <= 24'd0;
    end else if (srst_s) begin
      run_r   <= 1'b1;
      timer_r <= 24'd0;
    end else begin
      run_r   <= 1'b1;
      timer_r <= timer_nxt_s;
    end
  end

  // Accumulator next values include an edge seen on the current cycle, so an
  // edge on the closing cycle lands in the published count.
  always_comb begin
    acc_left_nxt_s  = sat_inc16(acc_left_r, edge_s[0]);
    acc_right_nxt_s = sat_inc16(acc_right_r, edge_s[1]);
  end

  // Window accumulators, published counts, valid strobe and odometers.
  // clr wins over a simultaneous window close and drops any edge it sees.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_left_r  <= 16'd0;
      acc_right_r <= 16'd0;
      out_left_r  <= 16'd0;
      out_right_r <= 16'd0;
      valid_r     <= 1'b0;
      odo_left_r  <= 32'd0;
      odo_right_r <= 32'd0;
    end else if (srst_s) begin
      acc_left_r  <= 16'd0;
      acc_right_r <= 16'd0;
      out_left_r  <= 16'd0;
      out_right_r <= 16'd0;
      valid_r     <= 1'b0;
      odo_left_r  <= 32'd0;
      odo_right_r <= 32'd0;
    end else begin
      odo_left_r  <= odo_left_r + {31'd0, edge_s[0]};
      odo_right_r <= odo_right_r + {31'd0, edge_s[1]};
      if (close_s) begin
        out_left_r  <= acc_left_nxt_s;
        out_right_r <= acc_right_nxt_s;
        acc_left_r  <= 16'd0;
        acc_right_r <= 16'd0;
        valid_r     <= 1'b1;
      end else begin
        acc_left_r  <= acc_left_nxt_s;
        acc_right_r <= acc_right_nxt_s;
        valid_r     <= 1'b0;
      end
    end
  end

  assign out_edge_l = out_left_r;
  assign out_edge_r = out_right_r;
  assign valid      = valid_r;
  assign odo_l      = odo_left_r;
  assign odo_r      = odo_right_r;

endmodule

// File: tb/tb_encoder_speed_meter.sv
// -----------------------------------------------------------------------------
// tb_encoder_speed_meter
//
// Directed bench for encoder_speed_meter. Main instance: WINDOW_CNT=100,
// FILT_LEN=1. Second instance: FILT_LEN=3, used for debounce behaviour.
// Cycle numbers below count rising clk edges since the latest reset release;
// inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_encoder_speed_meter;

  logic        clk = 1'b0;
  logic        n_rst, fbl, fbr, clr, fbl3, fbr3;
  logic [15:0] out_edge_l, out_edge_r, out3_l, out3_r;
  logic        valid, valid3;
  logic [31:0] odo_l, odo_r, odo3_l, odo3_r;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int base   = 0;
  int vcount = 0;
  int vcyc   = 0;
  int vsave  = 0;

  encoder_speed_meter #(.WINDOW_CNT(100), .FILT_LEN(1)) dut (
    .clk(clk), .n_rst(n_rst), .fbl(fbl), .fbr(fbr), .clr(clr),
    .out_edge_l(out_edge_l), .out_edge_r(out_edge_r), .valid(valid),
    .odo_l(odo_l), .odo_r(odo_r)
  );

  encoder_speed_meter #(.WINDOW_CNT(100), .FILT_LEN(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .fbl(fbl3), .fbr(fbr3), .clr(clr),
    .out_edge_l(out3_l), .out_edge_r(out3_r), .valid(valid3),
    .odo_l(odo3_l), .odo_r(odo3_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts valid pulses of the main instance and remembers the cycle of the last one.
  always @(posedge clk) begin
    if (valid === 1'b1) begin
      vcount <= vcount + 1;
      vcyc   <= cyc - base;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  task automatic pulse_l();
    fbl = 1'b1; @(negedge clk); fbl = 1'b0;
  endtask

  task automatic pulse_r();
    fbr = 1'b1; @(negedge clk); fbr = 1'b0;
  endtask

  task automatic pulse_lr();
    fbl = 1'b1; fbr = 1'b1; @(negedge clk); fbl = 1'b0; fbr = 1'b0;
  endtask

  initial begin
    n_rst = 1'b1; fbl = 1'b0; fbr = 1'b0; clr = 1'b0; fbl3 = 1'b0; fbr3 = 1'b0;
    #1 n_rst = 1'b0;
    #2;
    chk("rst_out_l", {16'd0, out_edge_l}, 32'd0);
    chk("rst_out_r", {16'd0, out_edge_r}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_odo_l", odo_l, 32'd0);
    chk("rst_odo_r", odo_r, 32'd0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    base  = cyc;

    // Window 1: three simultaneous pulses; latency FILT_LEN+3 = 4
    goto(2);  pulse_lr();
    goto(5);  chk("lat_before", odo_l, 32'd0);
    goto(6);  chk("lat_at_l", odo_l, 32'd1);
              chk("lat_at_r", odo_r, 32'd1);
    // FILT_LEN=3 instance: 1- and 2-cycle pulses rejected, 3-cycle accepted
    goto(10); fbl3 = 1'b1; @(negedge clk); fbl3 = 1'b0;
    goto(20); fbl3 = 1'b1; goto(22); fbl3 = 1'b0;
    goto(30); fbl3 = 1'b1; goto(33); fbl3 = 1'b0;
    goto(35); chk("f3_lat_before", odo3_l, 32'd0);
    goto(36); chk("f3_lat_at", odo3_l, 32'd1);
    goto(40); pulse_lr();
    goto(80); pulse_lr();
    goto(100);
    chk("w1_no_early_valid", {31'd0, valid}, 32'd0);
    chk("w1_odo_pre", odo_l, 32'd3);
    goto(101);
    chk("w1_valid", {31'd0, valid}, 32'd1);
    chk("w1_out_l", {16'd0, out_edge_l}, 32'd3);
    chk("w1_out_r", {16'd0, out_edge_r}, 32'd3);
    chk("w1_odo_l", odo_l, 32'd3);
    chk("w1_odo_r", odo_r, 32'd3);
    chk("f3_out_l", {16'd0, out3_l}, 32'd1);
    chk("f3_out_r", {16'd0, out3_r}, 32'd0);
    goto(102);
    chk("w1_valid_drop", {31'd0, valid}, 32'd0);
    chk("w1_vcount", 32'(vcount), 32'd1);
    chk("w1_vcyc", 32'(vcyc), 32'd101);

    // Edge on the closing cycle belongs to window 2, next cycle to window 3
    goto(197); pulse_l();
    goto(198); pulse_r();
    goto(201);
    chk("w2_close_edge_l", {16'd0, out_edge_l}, 32'd1);
    chk("w2_close_edge_r", {16'd0, out_edge_r}, 32'd0);
    goto(301);
    chk("w3_restart_l", {16'd0, out_edge_l}, 32'd0);
    chk("w3_first_cycle_r", {16'd0, out_edge_r}, 32'd1);
    chk("w3_odo_l", odo_l, 32'd4);
    chk("w3_odo_r", odo_r, 32'd4);

    // Odometer wrap
    goto(310); force dut.odo_left_r = 32'hFFFF_FFFE;
    goto(311); release dut.odo_left_r;
    goto(312); pulse_l();
    goto(320); chk("odo_near_wrap", odo_l, 32'hFFFF_FFFF);
    pulse_l();
    goto(330);
    chk("odo_wrap_l", odo_l, 32'd0);
    chk("odo_wrap_r_kept", odo_r, 32'd4);
    chk("odo_wrap_out_l_kept", {16'd0, out_edge_l}, 32'd0);
    chk("odo_wrap_out_r_kept", {16'd0, out_edge_r}, 32'd1);
    goto(401);
    chk("w4_out_l", {16'd0, out_edge_l}, 32'd2);

    // Accumulator saturation
    goto(410); force dut.acc_left_r = 16'hFFFE;
    goto(411); release dut.acc_left_r;
    goto(412); pulse_l();
    goto(420); pulse_l();
    goto(428); pulse_l();
    goto(501);
    chk("sat_out_l", {16'd0, out_edge_l}, 32'h0000_FFFF);
    chk("sat_odo_l", odo_l, 32'd3);

    // clr on the closing cycle with pending edges
    goto(550); pulse_r();
    goto(610); pulse_l();
    goto(620); pulse_l();
    goto(630); pulse_l();
    goto(640); pulse_l();
    goto(650); pulse_l();
    goto(697); pulse_l();
    goto(700);
    chk("clr_pre_odo_l", odo_l, 32'd8);
    chk("clr_pre_out_r", {16'd0, out_edge_r}, 32'd1);
    chk("clr_pre_vcount", 32'(vcount), 32'd6);
    clr = 1'b1;
    goto(701); clr = 1'b0;
    chk("clr_valid", {31'd0, valid}, 32'd0);
    chk("clr_out_l", {16'd0, out_edge_l}, 32'd0);
    chk("clr_out_r", {16'd0, out_edge_r}, 32'd0);
    chk("clr_odo_l", odo_l, 32'd0);
    chk("clr_odo_r", odo_r, 32'd0);
    goto(702); chk("clr_no_vpulse", 32'(vcount), 32'd6);
    goto(750); pulse_r();
    goto(800); chk("clr_no_early_valid", {31'd0, valid}, 32'd0);
    goto(801);
    chk("clr_next_valid", {31'd0, valid}, 32'd1);
    chk("clr_drop_edge_l", {16'd0, out_edge_l}, 32'd0);
    chk("clr_next_out_r", {16'd0, out_edge_r}, 32'd1);
    chk("clr_next_odo_l", odo_l, 32'd0);
    goto(802);
    chk("clr_vcount", 32'(vcount), 32'd7);
    chk("clr_vcyc", 32'(vcyc), 32'd801);

    // Asynchronous reset mid-window with 7 pending edges
    for (int i = 0; i < 7; i++) begin
      goto(810 + 10 * i); pulse_l();
    end
    goto(880);
    chk("ar_pre_odo_l", odo_l, 32'd7);
    #2 n_rst = 1'b0;
    #1;
    chk("ar_odo_l", odo_l, 32'd0);
    chk("ar_odo_r", odo_r, 32'd0);
    chk("ar_out_r", {16'd0, out_edge_r}, 32'd0);
    chk("ar_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    base  = cyc;
    vsave = vcount;
    goto(5);  pulse_l();
    goto(15); pulse_l();
    goto(100); chk("ar_no_early_valid", {31'd0, valid}, 32'd0);
    goto(101);
    chk("ar_valid_at_101", {31'd0, valid}, 32'd1);
    chk("ar_out_l", {16'd0, out_edge_l}, 32'd2);
    chk("ar_out_r_post", {16'd0, out_edge_r}, 32'd0);
    chk("ar_odo_l_post", odo_l, 32'd2);
    goto(102);
    chk("ar_vcount", 32'(vcount), 32'(vsave + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
